sync_up_counter: RTL and testbench
==================================

# sync_up_counter

Synchronous, fully clocked up counter: the counting-direction and clocking complement to the team's ripple-clocked asynchronous counter. All state bits change on the same `clk` edge, so there are no ripple-through glitches. The counter has a programmable modulus, a prescaler, parallel load, compare match and sticky overflow. It is the timebase and event-count source for downstream control logic, and cascades via `wrap`.

## Interface
- `WIDTH`, 4: counter width in bits.
- `MAX`, 15: terminal value; count range 0..MAX, MAX ≤ 2^WIDTH−1.
- `PRESCALE`, 1: enabled cycles per count step, ≥1.

- `clk` input 1: single clock; all state on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `en` input 1: count enable; low freezes counter and prescaler.
- `ld` input 1: parallel load strobe.
- `din` input WIDTH: load value.
- `cmp` input WIDTH: compare value.
- `ovf_clr` input 1: clears sticky overflow.
- `z` output WIDTH: current count.
- `tc` output 1: terminal count, level, `z==MAX`.
- `wrap` output 1: one-cycle pulse, registered, high in the cycle `z` shows 0 after a MAX→0 step.
- `match` output 1: level, `z==cmp`.
- `ovf` output 1: sticky, set by wrap.

## Operation
- Internal `tick` = `en` && prescaler at PRESCALE−1. With PRESCALE=1, `tick`=`en`.
- Per-edge priority:
  - `rst`: `z`=0, prescaler=0, `wrap`=0, `ovf`=0.
  - `ld`: `z`=min(`din`,MAX), prescaler=0, `wrap`=0. `ld` overrides `en`/`tick` in the same cycle.
  - `tick`: if `z`==MAX then `z`=0 and `wrap`=1; else `z`=`z`+1 and `wrap`=0.
  - otherwise: `z` holds, `wrap`=0.
- Prescaler:
  - Counts 0..PRESCALE−1 only while `en`=1 and `ld`=0.
  - Returns to 0 on the cycle it generates `tick`.
  - Holds its value while `en`=0, so a partial period is resumed, not restarted.
- `ovf`:
  - Set on any edge where `wrap` is being set.
  - Cleared by `ovf_clr`.
  - Simultaneous set and clear: set wins.
  - Reset clears it.
- `tc` and `match` are combinational from registered `z` and `cmp`; no latency beyond `z`.
- Arithmetic: unsigned WIDTH-bit; increment never exceeds MAX, so no modular overflow of WIDTH bits.
- Non-power-of-two MAX (e.g. 9 for BCD decade): wrap at MAX, values above MAX are unreachable except by reset-free power-up, which `rst` removes.
- Cascading: `wrap` of stage N drives `en` of stage N+1, with PRESCALE=1 in the upper stage.

## Timing
- After `rst` deasserts: `z`=0, `tc`=(MAX==0), `wrap`=0, `ovf`=0, `match`=(`cmp`==0).
- Load latency: `z` reflects `din` on the edge that samples `ld`, i.e. 1 cycle.
- Count latency with PRESCALE=P and `en` held high from reset: first increment visible after P edges.
- `wrap` is exactly one cycle wide, including when `en` stays high at PRESCALE=1 with MAX=0. In that case `z` stays 0, `wrap` is high every tick-cycle and asserts back-to-back.
- `rst` mid-count or mid-prescale: the next edge yields the full reset state; no residual prescaler phase.
- `ld` in the same cycle as a wrap: no wrap, and `ovf` is unchanged.

## Structure
- Package `sync_up_counter_pkg`:
  - default constants `DEF_WIDTH`, `DEF_MAX`, `DEF_PRESCALE`.
  - function `clamp_load(din, max)`.
- Sub-module `sync_prescaler`:
  - parameter PRESCALE; ports `clk`, `rst`, `en`, `clr`, `tick`.
  - `clr` is driven by `ld`.
  - PRESCALE=1 degenerates to `tick`=`en`, with no register.
- Top module holds the count register, wrap/ovf flops and compare logic. Add elaboration-time checks on MAX ≤ 2^WIDTH−1 and PRESCALE ≥ 1.

## Test plan
- Reset/count, WIDTH=4, MAX=15, P=1:
  - `rst` 2 cycles, then `en`=1 for 17 cycles → `z` 0,1..15,0.
  - `tc` high only at 15.
  - `wrap` high for one cycle with `z`=0.
  - `ovf`=1 thereafter.
- Decade, MAX=9, P=3, `en`=1 → `z` increments every 3rd edge, 0..9 then 0, `wrap` pulse width 1.
  - Drop `en` for 5 cycles mid-period → period resumes, not restarts.
- Load:
  - `ld`=1, `din`=12, MAX=9 → `z`=9, `tc`=1.
  - `ld` with `din`=5 at the wrap cycle → `z`=5, `wrap`=0, `ovf` unchanged.
- Overflow clear: `ovf_clr` pulse alone → `ovf`=0; `ovf_clr` coincident with wrap → `ovf`=1.
- Compare: `cmp`=7, count through → `match` high exactly while `z`=7.
- Mid-operation reset: `rst` at `z`=6 with prescaler phase 2 → next cycle `z`=0, and the first increment comes P edges after `rst` drops.

Source files
------------

// File: rtl/sync_up_counter_pkg.sv
// Shared defaults and helpers for the synchronous up counter.
package sync_up_counter_pkg;

  localparam int DEF_WIDTH    = 4;
  localparam int DEF_MAX      = 15;
  localparam int DEF_PRESCALE = 1;

  // Saturate a load value to the terminal count so out-of-range states are never loaded.
  function automatic int clamp_load(input int din, input int max);
    return (din > max) ? max : din;
  endfunction

endpackage

// File: rtl/sync_up_counter_prescaler.sv
// Prescaler: emits a one-cycle tick every PRESCALE enabled cycles; holds phase while en is low.
module sync_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  generate
    if (PRESCALE == 1) begin : g_bypass
      logic unused_inputs;
      assign unused_inputs = &{1'b0, clk, rst, clr};
      assign tick = en;
    end else begin : g_div
      localparam int CW = $clog2(PRESCALE);
      logic [CW-1:0] phase;

      assign tick = en && (phase == CW'(PRESCALE - 1));

      always_ff @(posedge clk) begin
        if (rst || clr) begin
          phase <= '0;
        end else if (en) begin
          if (tick) phase <= '0;
          else      phase <= phase + CW'(1);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/sync_up_counter.sv
// Fully synchronous modulo-(MAX+1) up counter with prescaler, load, compare and sticky overflow.
module sync_up_counter
  import sync_up_counter_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int MAX      = DEF_MAX,
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ld,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] cmp,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] z,
  output logic             tc,
  output logic             wrap,
  output logic             match,
  output logic             ovf
);

  generate
    if (MAX > (2 ** WIDTH) - 1) begin : g_bad_max
      $error("sync_up_counter: MAX does not fit in WIDTH bits");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
      $error("sync_up_counter: PRESCALE must be at least 1");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic tick;
  logic wrap_set;

  sync_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (ld),
    .tick (tick)
  );

  // A load in the wrap cycle suppresses both the wrap pulse and the overflow set.
  assign wrap_set = tick && !ld && (z == MAX_V);

  always_ff @(posedge clk) begin
    if (rst) begin
      z    <= '0;
      wrap <= 1'b0;
    end else if (ld) begin
      z    <= WIDTH'(clamp_load(int'(din), MAX));
      wrap <= 1'b0;
    end else if (tick) begin
      z    <= (z == MAX_V) ? '0 : z + WIDTH'(1);
      wrap <= (z == MAX_V);
    end else begin
      wrap <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)            ovf <= 1'b0;
    else if (wrap_set)  ovf <= 1'b1;
    else if (ovf_clr)   ovf <= 1'b0;
  end

  assign tc    = (z == MAX_V);
  assign match = (z == cmp);

endmodule

// File: tb/tb_sync_up_counter.sv
// Directed bench for sync_up_counter: table-driven vectors plus multi-cycle corner sequences.
module tb_sync_up_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instance A: WIDTH=4, MAX=15, PRESCALE=1
  logic a_rst = 1'b1, a_en = 1'b0, a_ld = 1'b0, a_clr = 1'b0;
  logic [3:0] a_din = 4'd0, a_cmp = 4'd7;
  logic [3:0] a_z;
  logic a_tc, a_wrap, a_match, a_ovf;

  // Instance B: WIDTH=4, MAX=9, PRESCALE=3
  logic b_rst = 1'b1, b_en = 1'b0, b_ld = 1'b0, b_clr = 1'b0;
  logic [3:0] b_din = 4'd0, b_cmp = 4'd0;
  logic [3:0] b_z;
  logic b_tc, b_wrap, b_match, b_ovf;

  // Instance C: WIDTH=4, MAX=0, PRESCALE=1
  logic c_rst = 1'b1, c_en = 1'b0, c_ld = 1'b0, c_clr = 1'b0;
  logic [3:0] c_din = 4'd0, c_cmp = 4'd0;
  logic [3:0] c_z;
  logic c_tc, c_wrap, c_match, c_ovf;

  sync_up_counter #(.WIDTH(4), .MAX(15), .PRESCALE(1)) dut_a (
    .clk(clk), .rst(a_rst), .en(a_en), .ld(a_ld), .din(a_din), .cmp(a_cmp),
    .ovf_clr(a_clr), .z(a_z), .tc(a_tc), .wrap(a_wrap), .match(a_match), .ovf(a_ovf)
  );

  sync_up_counter #(.WIDTH(4), .MAX(9), .PRESCALE(3)) dut_b (
    .clk(clk), .rst(b_rst), .en(b_en), .ld(b_ld), .din(b_din), .cmp(b_cmp),
    .ovf_clr(b_clr), .z(b_z), .tc(b_tc), .wrap(b_wrap), .match(b_match), .ovf(b_ovf)
  );

  sync_up_counter #(.WIDTH(4), .MAX(0), .PRESCALE(1)) dut_c (
    .clk(clk), .rst(c_rst), .en(c_en), .ld(c_ld), .din(c_din), .cmp(c_cmp),
    .ovf_clr(c_clr), .z(c_z), .tc(c_tc), .wrap(c_wrap), .match(c_match), .ovf(c_ovf)
  );

  typedef struct {
    logic       rst, en, ld, clr;
    logic [3:0] din;
    logic [3:0] z;
    logic       tc, wrap, match, ovf;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, e, l, c, input logic [3:0] d,
                              input logic [3:0] ez, input logic et, ew, em, eo);
    vec_t v;
    v.rst = r; v.en = e; v.ld = l; v.clr = c; v.din = d;
    v.z = ez; v.tc = et; v.wrap = ew; v.match = em; v.ovf = eo;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---------------- Instance A vectors ----------------
    add(1,0,0,0, 4'd0,  4'd0,  0,0,0,0);
    add(1,0,0,0, 4'd0,  4'd0,  0,0,0,0);
    for (int k = 1; k <= 16; k++)
      add(0,1,0,0, 4'd0, 4'(k % 16), (k == 15), (k == 16), (k == 7), (k >= 16));
    add(0,1,0,0, 4'd0,  4'd1,  0,0,0,1);
    add(0,0,0,1, 4'd0,  4'd1,  0,0,0,0);   // ovf_clr alone
    add(0,1,1,0, 4'd12, 4'd12, 0,0,0,0);   // ld overrides en
    add(0,1,0,0, 4'd0,  4'd13, 0,0,0,0);
    add(0,1,0,0, 4'd0,  4'd14, 0,0,0,0);
    add(0,1,0,0, 4'd0,  4'd15, 1,0,0,0);
    add(0,1,0,0, 4'd0,  4'd0,  0,1,0,1);
    add(0,0,1,0, 4'd15, 4'd15, 1,0,0,1);
    add(0,1,1,0, 4'd5,  4'd5,  0,0,0,1);   // ld at wrap cycle, ovf stays 1
    add(0,0,0,1, 4'd0,  4'd5,  0,0,0,0);
    add(0,0,1,0, 4'd15, 4'd15, 1,0,0,0);
    add(0,1,1,0, 4'd5,  4'd5,  0,0,0,0);   // ld at wrap cycle, ovf stays 0
    add(0,0,1,0, 4'd14, 4'd14, 0,0,0,0);
    add(0,1,0,0, 4'd0,  4'd15, 1,0,0,0);
    add(0,1,0,1, 4'd0,  4'd0,  0,1,0,1);   // set beats clear
    add(0,0,0,0, 4'd0,  4'd0,  0,0,0,1);
    add(0,0,0,1, 4'd0,  4'd0,  0,0,0,0);
    add(0,0,1,0, 4'd7,  4'd7,  0,0,1,0);   // compare hit via load

    for (int i = 0; i < tbl.size(); i++) begin
      a_rst = tbl[i].rst; a_en = tbl[i].en; a_ld = tbl[i].ld;
      a_clr = tbl[i].clr; a_din = tbl[i].din;
      step();
      chk($sformatf("a[%0d].z", i),     int'(a_z),     int'(tbl[i].z));
      chk($sformatf("a[%0d].tc", i),    int'(a_tc),    int'(tbl[i].tc));
      chk($sformatf("a[%0d].wrap", i),  int'(a_wrap),  int'(tbl[i].wrap));
      chk($sformatf("a[%0d].match", i), int'(a_match), int'(tbl[i].match));
      chk($sformatf("a[%0d].ovf", i),   int'(a_ovf),   int'(tbl[i].ovf));
    end
    a_en = 1'b0; a_ld = 1'b0; a_clr = 1'b0;

    // ---------------- Instance B: decade, prescale 3 ----------------
    b_rst = 1'b1;
    step(); step();
    chk("b.reset.z", int'(b_z), 0);
    chk("b.reset.wrap", int'(b_wrap), 0);
    chk("b.reset.tc", int'(b_tc), 0);
    chk("b.reset.match", int'(b_match), 1);
    chk("b.reset.ovf", int'(b_ovf), 0);
    b_rst = 1'b0; b_en = 1'b1;
    for (int n = 1; n <= 31; n++) begin
      step();
      chk($sformatf("b.count[%0d].z", n), int'(b_z), (n / 3) % 10);
      chk($sformatf("b.count[%0d].wrap", n), int'(b_wrap), (n == 30) ? 1 : 0);
      if (n == 30) chk("b.count.ovf", int'(b_ovf), 1);
    end
    b_en = 1'b0;
    for (int n = 0; n < 5; n++) begin
      step();
      chk($sformatf("b.pause[%0d].z", n), int'(b_z), 0);
    end
    b_en = 1'b1;
    step(); chk("b.resume1.z", int'(b_z), 0);
    step(); chk("b.resume2.z", int'(b_z), 1);
    b_en = 1'b0; b_ld = 1'b1; b_din = 4'd12;
    step();
    chk("b.clamp.z", int'(b_z), 9);
    chk("b.clamp.tc", int'(b_tc), 1);
    b_din = 4'd6;
    step(); chk("b.ld6.z", int'(b_z), 6);
    b_ld = 1'b0; b_en = 1'b1;
    step(); step();
    chk("b.phase2.z", int'(b_z), 6);
    b_rst = 1'b1;
    step();
    chk("b.midrst.z", int'(b_z), 0);
    chk("b.midrst.ovf", int'(b_ovf), 0);
    chk("b.midrst.wrap", int'(b_wrap), 0);
    b_rst = 1'b0;
    step(); chk("b.post1.z", int'(b_z), 0);
    step(); chk("b.post2.z", int'(b_z), 0);
    step(); chk("b.post3.z", int'(b_z), 1);
    b_en = 1'b0;

    // ---------------- Instance C: MAX=0 back-to-back wrap ----------------
    c_rst = 1'b1;
    step();
    chk("c.reset.z", int'(c_z), 0);
    chk("c.reset.tc", int'(c_tc), 1);
    chk("c.reset.wrap", int'(c_wrap), 0);
    chk("c.reset.match", int'(c_match), 1);
    chk("c.reset.ovf", int'(c_ovf), 0);
    c_rst = 1'b0; c_en = 1'b1;
    for (int n = 0; n < 3; n++) begin
      step();
      chk($sformatf("c.run[%0d].wrap", n), int'(c_wrap), 1);
      chk($sformatf("c.run[%0d].z", n), int'(c_z), 0);
      chk($sformatf("c.run[%0d].ovf", n), int'(c_ovf), 1);
    end
    c_en = 1'b0;
    step();
    chk("c.stop.wrap", int'(c_wrap), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
